// File: rtl/game_status_pkg.sv
// game_status_pkg
// Shared types and artwork for the game-status display block.
//   status_e   : top-level game state (PLAY / FLASH / GAMEOVER / WIN)
//   GG_GLYPH   : 16-row banner shown when the player runs out of lives
//   WIN_GLYPH  : 16-row banner shown when the frog reaches the goal
//   glyph_row  : looks up one 16-bit banner row for a terminal state
// Glyph rows are 16 bits wide with bit 15 as the leftmost column.
package game_status_pkg;

    typedef enum logic [1:0] {
        PLAY     = 2'd0,
        FLASH    = 2'd1,
        GAMEOVER = 2'd2,
        WIN      = 2'd3
    } status_e;

    localparam int GLYPH_W    = 16;
    localparam int GLYPH_ROWS = 16;

    // "GG" banner on the upper half, small lettering strip below it.
    localparam logic [15:0] GG_GLYPH [0:15] = '{
        16'h0000,
        16'h3C3C,
        16'h6666,
        16'h6060,
        16'h6E6E,
        16'h6666,
        16'h3E3E,
        16'h0000,
        16'h0000,
        16'h0000,
        16'h0000,
        16'h44EE,
        16'hAA8A,
        16'b0110011011101001,
        16'h4488,
        16'h0000
    };

    // "WIN" banner: W in the left five columns, I in the middle, N on the right.
    localparam logic [15:0] WIN_GLYPH [0:15] = '{
        16'h0000,
        16'h0000,
        16'h8BA2,
        16'h8932,
        16'hA92A,
        16'hA926,
        16'h53A2,
        16'h0000,
        16'h0000,
        16'h0000,
        16'h0000,
        16'h0000,
        16'h0000,
        16'h0000,
        16'h0000,
        16'h0000
    };

    // Banner row for a terminal state; every other state has no artwork.
    function automatic logic [15:0] glyph_row(input status_e s, input logic [3:0] idx);
        logic [15:0] row;
        row = 16'h0000;
        case (s)
            GAMEOVER: row = GG_GLYPH[idx];
            WIN:      row = WIN_GLYPH[idx];
            default:  row = 16'h0000;
        endcase
        return row;
    endfunction

endpackage

// File: rtl/game_status_display_if.sv
// game_status_display_if
// Bundles the game-side inputs and display-side outputs of the status block.
//   hit, win, frame_tick : game events and frame pacing (driven by master)
//   row_sel              : matrix row being scanned (driven by master)
//   pixels               : pixel pattern for row_sel (driven by slave)
//   lives                : remaining lives (driven by slave)
//   game_over, game_won  : terminal state flags (driven by slave)
//   freeze               : stalls frog/lane movement (driven by slave)
interface game_status_display_if #(
    parameter int WIDTH = 16,
    parameter int ROWS  = 16,
    parameter int LIVES = 3
);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int LIFE_W = $clog2(LIVES + 1);

    logic              hit;
    logic              win;
    logic              frame_tick;
    logic [ROW_W-1:0]  row_sel;
    logic [WIDTH-1:0]  pixels;
    logic [LIFE_W-1:0] lives;
    logic              game_over;
    logic              game_won;
    logic              freeze;

    modport master (
        output hit, win, frame_tick, row_sel,
        input  pixels, lives, game_over, game_won, freeze
    );

    modport slave (
        input  hit, win, frame_tick, row_sel,
        output pixels, lives, game_over, game_won, freeze
    );

endinterface

// File: rtl/game_status_display_glyph_rom.sv
// status_glyph_rom
// Purely combinational artwork stage: turns the current game state, blink
// phase and scanned row into one row of matrix pixels.
//   state       : current game state
//   blink_phase : FLASH blink half (1 = lit)
//   row_sel     : matrix row being scanned
//   pixels      : WIDTH-bit pixel pattern for that row
module status_glyph_rom
    import game_status_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ROWS  = 16,
    parameter int ROW_W = 4
) (
    input  status_e          state,
    input  logic             blink_phase,
    input  logic [ROW_W-1:0] row_sel,
    output logic [WIDTH-1:0] pixels
);

    // Glyphs are placed in the low 16 bits of a vector at least 16 wide, so a
    // wider matrix gets zero-padded upper columns and a narrower matrix keeps
    // only the low WIDTH columns.
    localparam int EXT_W = (WIDTH > GLYPH_W) ? WIDTH : GLYPH_W;

    logic [EXT_W-1:0] ext_row;
    int               row_i;

    // Rows outside the matrix are always dark; glyph rows past the artwork
    // height are dark too.
    always_comb begin
        row_i   = 32'(row_sel);
        ext_row = '0;
        pixels  = '0;
        if (row_i < ROWS) begin
            case (state)
                FLASH: begin
                    if (blink_phase) begin
                        pixels = '1;
                    end
                end
                GAMEOVER, WIN: begin
                    if (row_i < GLYPH_ROWS) begin
                        ext_row = EXT_W'(glyph_row(state, row_i[3:0]));
                        pixels  = ext_row[WIDTH-1:0];
                    end
                end
                default: pixels = '0;
            endcase
        end
    end

endmodule

// File: rtl/game_status_display.sv
// game_status_display
// Game-status controller for the LED matrix: tracks lives, runs the
// PLAY / FLASH / GAMEOVER / WIN sequence and drives one matrix row per
// selected row index.
//   clk    : system clock
//   reset  : synchronous, active-high reset
//   bus    : slave side of game_status_display_if
//            (hit, win, frame_tick, row_sel in; pixels, lives, game_over,
//             game_won, freeze out)
module game_status_display
    import game_status_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int ROWS         = 16,
    parameter int LIVES        = 3,
    parameter int FLASH_FRAMES = 8,
    parameter int BLINK_FRAMES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    game_status_display_if.slave  bus
);

    localparam int ROW_W  = $clog2(ROWS);
    localparam int LIFE_W = $clog2(LIVES + 1);
    localparam int FC_W   = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam int BC_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    status_e           state_q, state_d;
    logic [LIFE_W-1:0] lives_q, lives_d;
    logic [FC_W-1:0]   flash_cnt_q, flash_cnt_d;
    logic [BC_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic              blink_phase_q, blink_phase_d;

    // State and counter registers; reset wins over every input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= PLAY;
            lives_q       <= LIFE_W'(LIVES);
            flash_cnt_q   <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            lives_q       <= lives_d;
            flash_cnt_q   <= flash_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    // Next-state logic. A hit takes priority over a simultaneous win. The
    // FLASH window starts counting on the first tick after entry, so a tick
    // coinciding with the hit itself is not part of the window.
    always_comb begin
        state_d       = state_q;
        lives_d       = lives_q;
        flash_cnt_d   = flash_cnt_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;

        case (state_q)
            PLAY: begin
                if (bus.hit) begin
                    if (lives_q <= LIFE_W'(1)) begin
                        lives_d = '0;
                        state_d = GAMEOVER;
                    end else begin
                        lives_d       = lives_q - LIFE_W'(1);
                        flash_cnt_d   = FC_W'(FLASH_FRAMES - 1);
                        blink_cnt_d   = '0;
                        blink_phase_d = 1'b1;
                        state_d       = FLASH;
                    end
                end else if (bus.win) begin
                    state_d = WIN;
                end
            end

            FLASH: begin
                if (bus.frame_tick) begin
                    if (blink_cnt_q == BC_W'(BLINK_FRAMES - 1)) begin
                        blink_cnt_d   = '0;
                        blink_phase_d = ~blink_phase_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + BC_W'(1);
                    end

                    if (flash_cnt_q == '0) begin
                        state_d       = PLAY;
                        blink_cnt_d   = '0;
                        blink_phase_d = 1'b0;
                    end else begin
                        flash_cnt_d = flash_cnt_q - FC_W'(1);
                    end
                end
            end

            default: begin
                state_d = state_q;
            end
        endcase
    end

    // Status flags follow the state directly.
    always_comb begin
        bus.game_over = (state_q == GAMEOVER);
        bus.game_won  = (state_q == WIN);
        bus.freeze    = (state_q != PLAY);
    end

    assign bus.lives = lives_q;

    status_glyph_rom #(
        .WIDTH (WIDTH),
        .ROWS  (ROWS),
        .ROW_W (ROW_W)
    ) u_glyph_rom (
        .state       (state_q),
        .blink_phase (blink_phase_q),
        .row_sel     (bus.row_sel),
        .pixels      (bus.pixels)
    );

endmodule

// File: tb/tb_game_status_display.sv
// tb_game_status_display
// Directed bench for game_status_display: one instance with the default
// parameters and one with WIDTH=20, LIVES=5.
module tb_game_status_display;

    logic clk = 1'b0;
    logic reset_a;
    logic reset_b;

    int pass_count  = 0;
    int check_count = 0;

    always #5 clk = ~clk;

    game_status_display_if #(.WIDTH(16), .ROWS(16), .LIVES(3)) bus_a ();
    game_status_display_if #(.WIDTH(20), .ROWS(16), .LIVES(5)) bus_b ();

    game_status_display #(
        .WIDTH(16), .ROWS(16), .LIVES(3), .FLASH_FRAMES(8), .BLINK_FRAMES(2)
    ) dut_a (
        .clk   (clk),
        .reset (reset_a),
        .bus   (bus_a)
    );

    game_status_display #(
        .WIDTH(20), .ROWS(16), .LIVES(5), .FLASH_FRAMES(8), .BLINK_FRAMES(2)
    ) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (bus_b)
    );

    // Drive one clock edge worth of inputs on the chosen instance; event
    // inputs act as one-cycle pulses and are dropped after the edge.
    task automatic applyStimulus(input bit use_b, input logic h, input logic w, input logic t);
        if (use_b) begin
            bus_b.hit = h; bus_b.win = w; bus_b.frame_tick = t;
        end else begin
            bus_a.hit = h; bus_a.win = w; bus_a.frame_tick = t;
        end
        @(posedge clk);
        #1;
        bus_a.hit = 1'b0; bus_a.win = 1'b0; bus_a.frame_tick = 1'b0;
        bus_b.hit = 1'b0; bus_b.win = 1'b0; bus_b.frame_tick = 1'b0;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) begin
            pass_count++;
        end else begin
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic ticks(input bit use_b, input int n);
        for (int i = 0; i < n; i++) applyStimulus(use_b, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        reset_a = 1'b1;
        reset_b = 1'b1;
        bus_a.hit = 1'b0; bus_a.win = 1'b0; bus_a.frame_tick = 1'b0; bus_a.row_sel = '0;
        bus_b.hit = 1'b0; bus_b.win = 1'b0; bus_b.frame_tick = 1'b0; bus_b.row_sel = '0;

        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        reset_a = 1'b0;
        $display("[TB] reset and idle");
        checkOutput("rst_lives", 32'(bus_a.lives), 32'd3);
        checkOutput("rst_pixels", 32'(bus_a.pixels), 32'h0);
        checkOutput("rst_freeze", 32'(bus_a.freeze), 32'd0);
        checkOutput("rst_game_over", 32'(bus_a.game_over), 32'd0);
        checkOutput("rst_game_won", 32'(bus_a.game_won), 32'd0);

        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0);
        checkOutput("idle_lives", 32'(bus_a.lives), 32'd3);
        for (int r = 0; r < 16; r++) begin
            bus_a.row_sel = 4'(r);
            #1;
            checkOutput($sformatf("idle_pixels_row%0d", r), 32'(bus_a.pixels), 32'h0);
        end
        checkOutput("idle_freeze", 32'(bus_a.freeze), 32'd0);
        checkOutput("idle_game_over", 32'(bus_a.game_over), 32'd0);
        bus_a.row_sel = 4'd0;

        $display("[TB] single hit and flash window");
        applyStimulus(0, 1, 0, 0);
        checkOutput("hit1_lives", 32'(bus_a.lives), 32'd2);
        checkOutput("hit1_freeze", 32'(bus_a.freeze), 32'd1);
        checkOutput("hit1_pixels", 32'(bus_a.pixels), 32'hFFFF);
        ticks(0, 2);
        checkOutput("blink_t2", 32'(bus_a.pixels), 32'h0);
        checkOutput("blink_t2_freeze", 32'(bus_a.freeze), 32'd1);
        ticks(0, 2);
        checkOutput("blink_t4", 32'(bus_a.pixels), 32'hFFFF);
        ticks(0, 3);
        checkOutput("flash_t7_freeze", 32'(bus_a.freeze), 32'd1);
        checkOutput("flash_t7_pixels", 32'(bus_a.pixels), 32'h0);
        ticks(0, 1);
        checkOutput("flash_t8_freeze", 32'(bus_a.freeze), 32'd0);
        checkOutput("flash_t8_pixels", 32'(bus_a.pixels), 32'h0);
        checkOutput("flash_t8_lives", 32'(bus_a.lives), 32'd2);

        $display("[TB] reset during flash");
        applyStimulus(0, 1, 0, 0);
        checkOutput("hit2_lives", 32'(bus_a.lives), 32'd1);
        ticks(0, 3);
        reset_a = 1'b1;
        applyStimulus(0, 0, 0, 0);
        reset_a = 1'b0;
        checkOutput("rstflash_lives", 32'(bus_a.lives), 32'd3);
        checkOutput("rstflash_freeze", 32'(bus_a.freeze), 32'd0);
        checkOutput("rstflash_pixels", 32'(bus_a.pixels), 32'h0);

        $display("[TB] hit and win together with spare lives");
        applyStimulus(0, 1, 1, 0);
        checkOutput("hitwin3_lives", 32'(bus_a.lives), 32'd2);
        checkOutput("hitwin3_freeze", 32'(bus_a.freeze), 32'd1);
        checkOutput("hitwin3_won", 32'(bus_a.game_won), 32'd0);
        applyStimulus(0, 0, 1, 1);
        checkOutput("flash_win_ignored", 32'(bus_a.game_won), 32'd0);
        ticks(0, 7);
        checkOutput("hitwin3_exit_freeze", 32'(bus_a.freeze), 32'd0);
        checkOutput("hitwin3_exit_lives", 32'(bus_a.lives), 32'd2);

        $display("[TB] hit held through flash");
        reset_a = 1'b1;
        applyStimulus(0, 0, 0, 0);
        reset_a = 1'b0;
        applyStimulus(0, 1, 0, 1);
        checkOutput("hold_entry_lives", 32'(bus_a.lives), 32'd2);
        for (int i = 0; i < 7; i++) applyStimulus(0, 1, 0, 1);
        checkOutput("hold_t7_freeze", 32'(bus_a.freeze), 32'd1);
        checkOutput("hold_t7_lives", 32'(bus_a.lives), 32'd2);
        applyStimulus(0, 1, 0, 1);
        checkOutput("hold_t8_freeze", 32'(bus_a.freeze), 32'd0);
        checkOutput("hold_t8_lives", 32'(bus_a.lives), 32'd2);
        applyStimulus(0, 1, 0, 0);
        checkOutput("hold_rehit_lives", 32'(bus_a.lives), 32'd1);
        checkOutput("hold_rehit_freeze", 32'(bus_a.freeze), 32'd1);
        ticks(0, 8);
        checkOutput("last_life_play", 32'(bus_a.freeze), 32'd0);

        $display("[TB] last life lost");
        applyStimulus(0, 1, 1, 0);
        checkOutput("go_game_over", 32'(bus_a.game_over), 32'd1);
        checkOutput("go_game_won", 32'(bus_a.game_won), 32'd0);
        checkOutput("go_lives", 32'(bus_a.lives), 32'd0);
        checkOutput("go_freeze", 32'(bus_a.freeze), 32'd1);
        bus_a.row_sel = 4'd13;
        #1;
        checkOutput("go_row13", 32'(bus_a.pixels), 32'h66E9);
        bus_a.row_sel = 4'd2;
        #1;
        checkOutput("go_row2", 32'(bus_a.pixels), 32'h6666);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 0, 1, 0);
        checkOutput("go_hold_lives", 32'(bus_a.lives), 32'd0);
        checkOutput("go_hold_over", 32'(bus_a.game_over), 32'd1);
        checkOutput("go_hold_won", 32'(bus_a.game_won), 32'd0);

        reset_a = 1'b1;
        applyStimulus(0, 0, 0, 0);
        reset_a = 1'b0;
        checkOutput("rstgo_lives", 32'(bus_a.lives), 32'd3);
        checkOutput("rstgo_over", 32'(bus_a.game_over), 32'd0);
        checkOutput("rstgo_freeze", 32'(bus_a.freeze), 32'd0);
        checkOutput("rstgo_pixels", 32'(bus_a.pixels), 32'h0);

        $display("[TB] win");
        applyStimulus(0, 0, 1, 0);
        checkOutput("win_won", 32'(bus_a.game_won), 32'd1);
        checkOutput("win_over", 32'(bus_a.game_over), 32'd0);
        checkOutput("win_freeze", 32'(bus_a.freeze), 32'd1);
        bus_a.row_sel = 4'd4;
        #1;
        checkOutput("win_row4", 32'(bus_a.pixels), 32'hA92A);
        bus_a.row_sel = 4'd0;
        #1;
        checkOutput("win_row0", 32'(bus_a.pixels), 32'h0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("win_hit_lives", 32'(bus_a.lives), 32'd3);
        checkOutput("win_hit_won", 32'(bus_a.game_won), 32'd1);

        $display("[TB] wide instance with five lives");
        applyStimulus(1, 0, 0, 0);
        reset_b = 1'b0;
        checkOutput("b_rst_lives", 32'(bus_b.lives), 32'd5);
        checkOutput("b_rst_pixels", 32'(bus_b.pixels), 32'h0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1, 1, 0, 0);
            checkOutput($sformatf("b_hit%0d_lives", i), 32'(bus_b.lives), 32'(5 - i));
            checkOutput($sformatf("b_hit%0d_pixels", i), 32'(bus_b.pixels), 32'hFFFFF);
            checkOutput($sformatf("b_hit%0d_over", i), 32'(bus_b.game_over), 32'd0);
            ticks(1, 8);
            checkOutput($sformatf("b_hit%0d_exit", i), 32'(bus_b.freeze), 32'd0);
        end
        applyStimulus(1, 1, 0, 0);
        checkOutput("b_go_over", 32'(bus_b.game_over), 32'd1);
        checkOutput("b_go_lives", 32'(bus_b.lives), 32'd0);
        bus_b.row_sel = 4'd13;
        #1;
        checkOutput("b_go_row13", 32'(bus_b.pixels), 32'h066E9);
        reset_b = 1'b1;
        applyStimulus(1, 0, 0, 0);
        reset_b = 1'b0;
        checkOutput("b_rstgo_lives", 32'(bus_b.lives), 32'd5);
        checkOutput("b_rstgo_pixels", 32'(bus_b.pixels), 32'h0);
        checkOutput("b_rstgo_over", 32'(bus_b.game_over), 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/game_status_display.md
Name: game_status_display

Overview:
- Parametrised game-status controller for the LED matrix.
- Tracks remaining lives and sequences PLAY / FLASH / GAMEOVER / WIN.
- Drives one matrix row of pixels per selected row index. During FLASH the output blinks the full row; in terminal states it shows a banner glyph.
- Sits beside the frog/lane logic. The freeze output stalls game movement during FLASH and terminal states.

Parameters:
- WIDTH, 16, pixel columns per row.
- ROWS, 16, matrix rows; ROW_W = $clog2(ROWS).
- LIVES, 3, starting lives (>=1); LIFE_W = $clog2(LIVES+1).
- FLASH_FRAMES, 8, frame ticks spent in FLASH after a non-fatal hit (>=1).
- BLINK_FRAMES, 2, frame ticks per blink half-period (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- hit  in  1  frog collision, level or pulse, sampled every cycle
- win  in  1  frog reached goal, sampled every cycle
- frame_tick  in  1  one-cycle pulse per display frame
- row_sel  in  ROW_W  row currently being driven
- pixels  out  WIDTH  pixel pattern for row_sel
- lives  out  LIFE_W  remaining lives
- game_over  out  1  high in GAMEOVER
- game_won  out  1  high in WIN
- freeze  out  1  high in FLASH, GAMEOVER or WIN

Behaviour:
- Reset applies on the clk edge with reset=1 and overrides all inputs. Reset values:
  - state=PLAY, lives=LIVES, flash_cnt=0, blink_cnt=0, blink_phase=0.
  - pixels=0, game_over=0, game_won=0, freeze=0.
- Reset mid-FLASH or mid-terminal state returns to PLAY with full lives on the next edge.
- State register updates on posedge clk. pixels, game_over, game_won and freeze are combinational from state, blink_phase and row_sel. lives is registered.
- PLAY:
  - hit && lives==1: lives<=0, go to GAMEOVER.
  - hit && lives>1: lives<=lives-1, flash_cnt<=FLASH_FRAMES-1, blink_cnt<=0, blink_phase<=1, go to FLASH.
  - win && !hit: go to WIN.
  - hit and win in the same cycle: hit wins.
  - Otherwise stay.
- FLASH:
  - hit and win are ignored (invulnerability window).
  - On frame_tick with flash_cnt==0: go to PLAY, blink_phase<=0.
  - On frame_tick with flash_cnt!=0: flash_cnt decrements.
  - blink_cnt increments on frame_tick. When blink_cnt reaches BLINK_FRAMES-1 it clears and blink_phase toggles.
  - Without frame_tick the state holds indefinitely.
  - Duration is exactly FLASH_FRAMES frame_ticks after entry. The entry cycle counts no tick, even if frame_tick is high that cycle.
- GAMEOVER and WIN are absorbing; only reset exits. All inputs are ignored, lives is frozen.
- pixels:
  - PLAY: all zeros.
  - FLASH: all ones if blink_phase=1, else zeros.
  - GAMEOVER: GG_GLYPH[row_sel].
  - WIN: WIN_GLYPH[row_sel].
  - row_sel >= ROWS: zeros.
- Glyphs are 16 bits wide, bit 15 = leftmost column.
  - WIDTH>16: the glyph occupies bits [15:0], upper bits are 0.
  - WIDTH<16: the low WIDTH bits are used.
- lives never underflows. A decrement happens only from PLAY with lives>=1.

Decomposition:
- Package game_status_pkg holds:
  - state enum typedef status_e {PLAY, FLASH, GAMEOVER, WIN}.
  - GG_GLYPH and WIN_GLYPH as 16-entry arrays of 16-bit constants. GG_GLYPH[13] = 16'b0110011011101001, other rows defined per the art sheet.
- One sub-module, status_glyph_rom: combinational, takes state, blink_phase and row_sel, returns pixels. Keeps the FSM/counters separate from artwork.

Test Plan:
- Reset, then idle 10 cycles -> lives=3, pixels=0 for all row_sel, freeze=0, game_over=0.
- 1-cycle hit in PLAY -> next cycle lives=2, state FLASH, freeze=1, pixels=16'hFFFF. After 2 frame_ticks pixels=0, after 4 =FFFF. After the 8th frame_tick: PLAY, freeze=0.
- hit held high through an entire FLASH window -> lives drops by exactly 1 during FLASH. On return to PLAY with hit still high, lives drops again (2->1) on the next cycle.
- Three separated hits -> lives 3->2->1->0, game_over=1. row_sel=13 gives pixels=16'b0110011011101001. Further hit/win pulses change nothing.
- hit and win asserted together in PLAY with lives=1 -> GAMEOVER, game_won=0. With lives=3 the same stimulus -> FLASH and lives=2. win alone -> WIN, game_won=1, pixels=WIN_GLYPH[row_sel].
- reset pulsed while in FLASH and again while in GAMEOVER -> next cycle PLAY, lives=3, pixels=0. Repeat the same checks at WIDTH=20, LIVES=5: upper 4 pixel bits are 0 and it takes 5 hits to reach game_over.
